// File: rtl/mem_stage_if.sv
// Pipeline-facing signals of the memory stage: EXE handoff, WB handoff, data RAM, bypass.
// Latency: none (wires only).
// Backpressure: MEM_allow_in upstream, WB_allow_in downstream, cancel flushes.
interface mem_stage_if;
  localparam int EXE_BUS_W = 159;
  localparam int WB_BUS_W  = 121;

  logic                 EXE_over;
  logic [EXE_BUS_W-1:0] EXE_MEM_bus;
  logic                 MEM_allow_in;
  logic                 WB_allow_in;
  logic                 cancel;
  logic                 MEM_valid;
  logic                 MEM_over;
  logic [WB_BUS_W-1:0]  MEM_WB_bus;
  logic [31:0]          dm_addr;
  logic [3:0]           dm_wen;
  logic [31:0]          dm_wdata;
  logic [31:0]          dm_rdata;
  logic [4:0]           MEM_wdest;
  logic                 MEM_rf_wen;
  logic [31:0]          MEM_result;
  logic [31:0]          MEM_pc;

  // the stage itself
  modport master (
    input  EXE_over, EXE_MEM_bus, WB_allow_in, cancel, dm_rdata,
    output MEM_allow_in, MEM_valid, MEM_over, MEM_WB_bus, dm_addr, dm_wen,
           dm_wdata, MEM_wdest, MEM_rf_wen, MEM_result, MEM_pc
  );

  // the surrounding pipeline and data RAM
  modport slave (
    output EXE_over, EXE_MEM_bus, WB_allow_in, cancel, dm_rdata,
    input  MEM_allow_in, MEM_valid, MEM_over, MEM_WB_bus, dm_addr, dm_wen,
           dm_wdata, MEM_wdest, MEM_rf_wen, MEM_result, MEM_pc
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: EXE->MEM register, data RAM load/store, misalignment detect, load shaping.
// Latency: capture to MEM_over is 1 cycle for non-memory/store/misaligned, 2 for loads.
// Backpressure: holds the result until WB_allow_in; accepts new work on handoff; cancel flushes.
module mem_stage (
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.master io
);
  typedef struct packed {
    logic [7:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret, rf_wen;
    logic [4:0]  rf_wdest;
    logic        overflow;
    logic [31:0] pc;
  } exe_bus_t;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret, overflow, adel, ades;
    logic [31:0] pc;
  } wb_bus_t;

  typedef enum logic [1:0] {IDLE, ISSUE, LOAD_WAIT, DONE} state_t;

  state_t      state;
  logic        valid;
  exe_bus_t    r;
  exe_bus_t    in_bus;
  wb_bus_t     wb;
  logic [31:0] load_buf;
  logic [31:0] shaped;
  logic [31:0] mem_result;
  logic [3:0]  wen_mask;
  logic [31:0] wdata;
  logic        unused_bits;

  // Half needs addr[0]=0, word needs addr[1:0]=0; byte is always aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == 2'b01) && a[0]) || (size[1] && (a != 2'b00));
  endfunction

  assign in_bus = io.EXE_MEM_bus;

  logic r_load, r_store, r_mis, in_mem_ok, over, handoff, capture;
  assign r_load    = r.mem_control[7];
  assign r_store   = r.mem_control[6];
  assign r_mis     = (r_load | r_store) & misaligned(r.mem_control[5:4], r.exe_result[1:0]);
  assign in_mem_ok = (in_bus.mem_control[7] | in_bus.mem_control[6]) &
                     ~misaligned(in_bus.mem_control[5:4], in_bus.exe_result[1:0]);

  // A store is complete in its issue cycle; a load needs the RAM's extra cycle.
  assign over    = ((state == ISSUE) && r_store) || (state == LOAD_WAIT) || (state == DONE);
  assign handoff = over & io.WB_allow_in;
  assign io.MEM_allow_in = ~valid | handoff;
  assign capture = io.EXE_over & io.MEM_allow_in & ~io.cancel;

  // Stage state: cancel beats capture beats handoff beats normal progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      valid    <= 1'b0;
      r        <= '0;
      load_buf <= '0;
    end else if (io.cancel) begin
      state <= IDLE;
      valid <= 1'b0;
    end else if (capture) begin
      r     <= in_bus;
      valid <= 1'b1;
      state <= in_mem_ok ? ISSUE : DONE;
    end else if (handoff) begin
      state <= IDLE;
      valid <= 1'b0;
    end else begin
      case (state)
        ISSUE:     state <= r_load ? LOAD_WAIT : DONE;
        LOAD_WAIT: begin
          load_buf <= shaped;
          state    <= DONE;
        end
        default:   state <= state;
      endcase
    end
  end

  // Little-endian lane select of the live RAM word, then extension.
  always_comb begin
    shaped = io.dm_rdata;
    case (r.mem_control[5:4])
      2'b00: begin
        case (r.exe_result[1:0])
          2'd0:    shaped = {24'b0, io.dm_rdata[7:0]};
          2'd1:    shaped = {24'b0, io.dm_rdata[15:8]};
          2'd2:    shaped = {24'b0, io.dm_rdata[23:16]};
          default: shaped = {24'b0, io.dm_rdata[31:24]};
        endcase
        if (r.mem_control[3] && shaped[7]) shaped[31:8] = '1;
      end
      2'b01: begin
        shaped = {16'b0, r.exe_result[1] ? io.dm_rdata[31:16] : io.dm_rdata[15:0]};
        if (r.mem_control[3] && shaped[15]) shaped[31:16] = '1;
      end
      default: shaped = io.dm_rdata;
    endcase
  end

  // Store lanes and replicated write data; enables only fire in ISSUE.
  always_comb begin
    case (r.mem_control[5:4])
      2'b00: begin
        wen_mask = 4'b0001 << r.exe_result[1:0];
        wdata    = {4{r.store_data[7:0]}};
      end
      2'b01: begin
        wen_mask = r.exe_result[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{r.store_data[15:0]}};
      end
      default: begin
        wen_mask = 4'b1111;
        wdata    = r.store_data;
      end
    endcase
  end

  assign io.dm_wen   = ((state == ISSUE) && r_store && !r_mis && !io.cancel) ? wen_mask : 4'b0000;
  assign io.dm_wdata = wdata;
  assign io.dm_addr  = r.exe_result;

  // Misaligned accesses report the faulting address as their result.
  assign mem_result = r_mis               ? r.exe_result :
                      (state == LOAD_WAIT) ? shaped       :
                      r_load              ? load_buf     : r.exe_result;

  assign wb = '{rf_wen: r.rf_wen, rf_wdest: r.rf_wdest, mem_result: mem_result,
                lo_result: r.lo_result, hi_write: r.hi_write, lo_write: r.lo_write,
                mfhi: r.mfhi, mflo: r.mflo, mtc0: r.mtc0, mfc0: r.mfc0,
                cp0r_addr: r.cp0r_addr, syscall: r.syscall, eret: r.eret,
                overflow: r.overflow, adel: r_load & r_mis, ades: r_store & r_mis,
                pc: r.pc};

  assign io.MEM_WB_bus = wb;
  assign io.MEM_valid  = valid;
  assign io.MEM_over   = over;
  assign io.MEM_wdest  = r.rf_wdest & {5{valid}};
  assign io.MEM_rf_wen = r.rf_wen & valid;
  assign io.MEM_result = mem_result;
  assign io.MEM_pc     = r.pc;

  assign unused_bits = ^r.mem_control[2:0];
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It owns the EXE->MEM pipeline register, drives the synchronous data RAM for loads and stores, and detects misaligned accesses. It shapes load data and presents the MEM->WB bus plus bypass info to decode.

Parameters:
EXE_BUS_W, 159, EXE->MEM bus width (fixed layout, not overridable)
WB_BUS_W, 121, MEM->WB bus width (fixed layout, not overridable)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
EXE_over  in  1  execute stage holds a finished instruction
EXE_MEM_bus  in  159  MSB->LSB: mem_control[8], store_data[32], exe_result[32], lo_result[32], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[8], syscall, eret, rf_wen, rf_wdest[5], overflow, pc[32]
MEM_allow_in  out  1  stage can accept a new instruction this cycle
WB_allow_in  in  1  writeback accepts this cycle
cancel  in  1  exception/eret flush from writeback
MEM_valid  out  1  stage holds a live instruction
MEM_over  out  1  stage result complete
MEM_WB_bus  out  121  MSB->LSB: rf_wen, rf_wdest[5], mem_result[32], lo_result[32], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[8], syscall, eret, overflow, adel, ades, pc[32]
dm_addr  out  32  data RAM byte address
dm_wen  out  4  data RAM byte write enables
dm_wdata  out  32  data RAM write data
dm_rdata  in  32  data RAM read data, valid one cycle after the address edge
MEM_wdest  out  5  rf_wdest & {5{MEM_valid}}, for hazard detection
MEM_rf_wen  out  1  rf_wen & MEM_valid
MEM_result  out  32  bypass value, meaningful only when MEM_over
MEM_pc  out  32  registered pc, for display

Behaviour:
- Clock is clk. Reset resetn is asynchronous, active-low. Under reset: MEM_valid=0, state=IDLE, bus register=0. So MEM_over=0, MEM_allow_in=1, dm_wen=0, dm_addr=0, MEM_WB_bus=0, MEM_wdest=0, MEM_rf_wen=0, MEM_pc=0.
- mem_control: [7] load, [6] store, [5:4] size (00 byte, 01 half, 10/11 word), [3] sign-extend loads, [2:0] ignored.
- MEM_allow_in = ~MEM_valid | (MEM_over & WB_allow_in). Capture occurs when EXE_over & MEM_allow_in & ~cancel: latch the bus and set MEM_valid=1.
- dm_addr = registered exe_result at all times.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. adel=load&misalign, ades=store&misalign. A misaligned access never asserts dm_wen. On misalignment, mem_result=exe_result (BadVAddr).
- FSM states: IDLE, ISSUE, LOAD_WAIT, DONE. State on capture:
  - aligned load or store -> ISSUE
  - anything else, including misaligned access -> DONE
- ISSUE lasts exactly one cycle.
  - Store: dm_wen is asserted only in ISSUE. Byte: dm_wen=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}. Half: dm_wen=addr[1]?1100:0011, wdata={2{sd[15:0]}}. Word: dm_wen=1111, wdata=sd.
  - Store sets MEM_over=1 in ISSUE. Next state is IDLE/ISSUE/DONE per the handoff and capture rules.
  - Load: MEM_over=0 in ISSUE; next state is LOAD_WAIT.
- LOAD_WAIT: MEM_over=1, mem_result = shaped live dm_rdata. Shaping selects the byte by addr[1:0] or the half by addr[1] (little-endian), then sign- or zero-extends per [3]. Without a handoff, latch the shaped value into load_buf and go to DONE.
- DONE: MEM_over=1. mem_result = load_buf for loads, otherwise exe_result. Holds until handoff.
- Handoff occurs when MEM_over & WB_allow_in. If capture happens in the same cycle, the next state follows the new instruction; otherwise MEM_valid=0 and state=IDLE.
- Latency from capture edge to MEM_over: non-memory 1 cycle, store 1 cycle, load 2 cycles.
- cancel (one cycle): forces dm_wen=0 that cycle and suppresses capture. Next edge: MEM_valid=0, state=IDLE. An in-flight store still in ISSUE is squashed. cancel has priority over all other events.
- MEM_result equals mem_result. MEM_pc equals registered pc.
- Reset asserted mid-access returns to the reset values immediately, with no partial write beyond the edge already taken.

Test Plan:
- Non-memory op: capture with exe_result=0x12345678, WB_allow_in=1 -> MEM_over=1 one cycle later, mem_result=0x12345678, dm_wen=0 throughout.
- Store byte: sd=0x000000AB, addr=0x103 -> in ISSUE, dm_wen=1000 and dm_wdata=0xABABABAB for one cycle only, even with WB_allow_in held 0 for 3 cycles.
- Load half signed: addr=0x102, dm_rdata=0x8001FFFF -> mem_result=0xFFFF8001 in LOAD_WAIT. With a 2-cycle WB stall, 0xFFFF8001 holds after dm_rdata changes to 0.
- Misaligned load word: addr=0x101 -> no ISSUE, adel=1, ades=0, mem_result=0x00000101, MEM_over one cycle after capture.
- cancel asserted in ISSUE of a store word at 0x200 -> dm_wen=0, MEM_valid=0 next cycle, no capture that cycle.
- Back-to-back loads with WB_allow_in=1 -> the second load is captured in the first load's LOAD_WAIT cycle. Each returns correct data, and MEM_allow_in=0 during ISSUE.
